seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16, clock cycles each digit stays selected (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wr_en  input  1  one-cycle strobe from write-back phase: latch wr_data for display.
REQ-005 SHALL have port wr_data  input  32  value to display, 8 hex nibbles; nibble i shown on digit i.
REQ-006 SHALL have port phase  input  3  current processor phase (0=F,1=R,2=X,3=M,4=W).
REQ-007 SHALL have port blank_lz  input  1  1 = blank leading zero digits.
REQ-008 SHALL have port seg_out  output  64  segment patterns; seg_out[8i+7:8i] = digit i as {dp,g,f,e,d,c,b,a}, 1 = lit.
REQ-009 SHALL have port seg_sel  output  8  one-hot digit select, bit i = digit i enabled.

Function
REQ-010 SHALL hold a 32-bit display register, loaded from wr_data on a rising edge with wr_en=1, otherwise unchanged.
REQ-011 SHALL register seg_out; a wr_en sampled at edge N is reflected in seg_out immediately after edge N (1-cycle latency from strobe).
REQ-012 SHALL encode nibble values 0..F as 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 in bits [6:0].
REQ-013 SHALL set dp (bit 7) of digit k only when registered phase == k, k in 0..4; phase 5..7 lights no dp.
REQ-014 SHALL register phase every cycle independent of wr_en; dp change visible 1 cycle after phase changes.
REQ-015 SHALL, when blank_lz=1, force bits [6:0] of digit i to 0 if nibbles 7..i of the display register are all zero, for i = 7..1.
REQ-016 SHALL never blank digit 0 (value 0 shows "0" with blank_lz=1).
REQ-017 SHALL not blank dp bits; dp follows REQ-013 regardless of blanking.
REQ-018 SHALL apply blank_lz combinationally into the seg_out register, taking effect 1 cycle after blank_lz changes.
REQ-019 SHALL run a prescaler counting 0..SCAN_DIV-1, wrapping to 0; seg_sel rotates left by one bit on the cycle the prescaler wraps.
REQ-020 SHALL wrap seg_sel from 8'b1000_0000 to 8'b0000_0001.
REQ-021 SHALL keep seg_sel exactly one-hot at all times out of reset.
REQ-022 SHALL not let wr_en, phase or blank_lz affect prescaler or seg_sel timing.
REQ-023 SHALL, on wr_en asserted on consecutive cycles, display the last written value; no write is queued.

Reset
REQ-024 SHALL, while rst=1, immediately force display register 0, registered phase 7, prescaler 0, seg_out 64'h0, seg_sel 8'b0000_0001.
REQ-025 SHALL, on reset asserted mid-scan or mid-write, discard the in-flight value; a wr_en coincident with rst=1 is ignored.
REQ-026 SHALL start counting on the first rising edge after rst deasserts; first seg_sel rotation occurs SCAN_DIV edges later.

Verification
REQ-027 Reset then release, SCAN_DIV=4 -> seg_out=0; seg_sel 01 for 4 cycles, then 02, ..., 80, back to 01 after 32 cycles.
REQ-028 wr_en=1, wr_data=32'h0123_ABCD, blank_lz=0, phase=7 -> next cycle seg_out=64'h3F06_5B4F_777C_395E.
REQ-029 Same data, blank_lz=1 -> digit 7 = 00, others unchanged; wr_data=0 -> only digit 0 = 3F, digits 7..1 = 00.
REQ-030 phase stepped 0,1,2,3,4,5 one per cycle -> dp lit on digit 0,1,2,3,4, then none, each 1 cycle later; digit bits [6:0] unchanged.
REQ-031 wr_en on two consecutive cycles (h11111111 then h22222222) -> seg_out shows 06 ×8 then 5B ×8; rst pulsed mid-scan -> seg_out=0, seg_sel=01 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/seg_scan_driver_if.sv
// Display bus for the 8-digit scanned seven-segment driver: write strobe,
// data, processor phase and blanking control in; segment patterns and
// digit select out.
interface seg_scan_driver_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [2:0]  phase;
    logic        blank_lz;
    logic [63:0] seg_out;
    logic [7:0]  seg_sel;

    // Side that feeds data to the display (processor / testbench)
    modport master (
        output wr_en,
        output wr_data,
        output phase,
        output blank_lz,
        input  seg_out,
        input  seg_sel
    );

    // Display driver side
    modport slave (
        input  wr_en,
        input  wr_data,
        input  phase,
        input  blank_lz,
        output seg_out,
        output seg_sel
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Eight-digit hex display driver. Holds the last written 32-bit value,
// renders every digit as a seven-segment pattern (with optional leading
// zero blanking and a phase marker on the dp of digits 0..4), and rotates
// a one-hot digit select every SCAN_DIV clock cycles.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic          clk,
    input  logic          rst,
    seg_scan_driver_if.slave bus
);

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

    // Display value and its next state
    logic [31:0] disp_q;
    logic [31:0] disp_d;

    // Registered processor phase; dp bits are decoded from it
    logic [2:0]  phase_q;

    // Seven-segment bits [6:0] of every digit, dp positions held at zero
    logic [63:0] seg_q;
    logic [63:0] seg_d;

    // Scan prescaler and digit select
    logic [15:0] presc_q;
    logic [15:0] presc_d;
    logic        presc_wrap;
    logic [7:0]  sel_q;
    logic [7:0]  sel_d;

    // Per-digit helpers
    logic [3:0]  nib      [8];
    logic [6:0]  seg_pat  [8];
    logic [8:0]  lead_zero;    // lead_zero[i]: nibbles 7..i of disp_d all zero
    logic [7:0]  dp_bits;

    // Hex nibble to {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // A write shows up in the segment register on the same edge that loads it,
    // so the patterns are built from the next display value, not the current one
    always_comb begin
        disp_d = disp_q;
        if (bus.wr_en) begin
            disp_d = bus.wr_data;
        end
    end

    assign lead_zero[8] = 1'b1;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            assign nib[gi]       = disp_d[4*gi +: 4];
            assign lead_zero[gi] = lead_zero[gi+1] & (nib[gi] == 4'h0);

            // Digit 0 is never blanked so a zero value still reads "0"
            if (gi == 0) begin : g_no_blank
                assign seg_pat[gi] = hex_to_seg(nib[gi]);
            end else begin : g_blank
                assign seg_pat[gi] = (bus.blank_lz && lead_zero[gi]) ? 7'h00
                                                                     : hex_to_seg(nib[gi]);
            end

            assign seg_d[8*gi +: 8] = {1'b0, seg_pat[gi]};

            // Only phases 0..4 have a digit to mark; 5..7 light no dp
            if (gi <= 4) begin : g_dp
                assign dp_bits[gi] = (phase_q == 3'(gi));
            end else begin : g_no_dp
                assign dp_bits[gi] = 1'b0;
            end

            assign bus.seg_out[8*gi +: 8] = {dp_bits[gi], seg_q[8*gi +: 7]};
        end
    endgenerate

    // Prescaler and digit rotation: advance select once per SCAN_DIV cycles
    always_comb begin
        presc_wrap = (presc_q == PRESC_LAST);
        presc_d    = presc_wrap ? 16'd0 : presc_q + 16'd1;
        sel_d      = presc_wrap ? {sel_q[6:0], sel_q[7]} : sel_q;
    end

    // Display value, phase and segment patterns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q  <= 32'h0;
            phase_q <= 3'd7;
            seg_q   <= 64'h0;
        end else begin
            disp_q  <= disp_d;
            phase_q <= bus.phase;
            seg_q   <= seg_d;
        end
    end

    // Scan timing, independent of writes, phase and blanking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= 16'd0;
            sel_q   <= 8'b0000_0001;
        end else begin
            presc_q <= presc_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.seg_sel = sel_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic rst;

    seg_scan_driver_if bus ();

    seg_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [31:0] m_disp  = 32'h0;
    logic [2:0]  m_phase = 3'd7;
    logic        m_blank = 1'b0;
    int          m_edges = 0;     // rising edges since reset released

    function automatic logic [63:0] model_seg(input logic [31:0] v, input logic [2:0] ph,
                                              input logic bl);
        logic [63:0] r;
        logic [7:0]  d;
        r = 64'h0;
        for (int k = 0; k < 8; k++) begin
            d = {1'b0, seg_tab[(v >> (4*k)) & 32'hF]};
            if (bl && k > 0 && (v >> (4*k)) == 32'h0) d = 8'h00;
            if (int'(ph) == k && k <= 4) d[7] = 1'b1;
            r[8*k +: 8] = d;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_disp  = 32'h0;
            m_phase = 3'd7;
            m_blank = 1'b0;
            m_edges = 0;
        end else begin
            if (bus.wr_en) m_disp = bus.wr_data;
            m_phase = bus.phase;
            m_blank = bus.blank_lz;
            m_edges = m_edges + 1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        logic [63:0] e_seg;
        logic [7:0]  e_sel;
        e_seg = (m_edges == 0) ? 64'h0 : model_seg(m_disp, m_phase, m_blank);
        e_sel = 8'h1 << ((m_edges / SCAN_DIV) % 8);
        n_cmp++;
        if (bus.seg_out !== e_seg) begin
            n_bad++;
            $display("FAIL model_seg_out t=%0t got=%h exp=%h", $time, bus.seg_out, e_seg);
        end
        n_cmp++;
        if (bus.seg_sel !== e_sel) begin
            n_bad++;
            $display("FAIL model_seg_sel t=%0t got=%h exp=%h", $time, bus.seg_sel, e_sel);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    task automatic wr(input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    logic [63:0] ph_exp [6] = '{64'h3F065B4F777C39DE, 64'h3F065B4F777CB95E,
                                64'h3F065B4F77FC395E, 64'h3F065B4FF77C395E,
                                64'h3F065BCF777C395E, 64'h3F065B4F777C395E};

    initial begin
        rst          = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 32'h0;
        bus.phase    = 3'd7;
        bus.blank_lz = 1'b0;
        #1 rst = 1'b1;
        // A write during reset must be discarded
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'hFFFF_FFFF;
        tick(3);
        chk64("reset_seg_out", bus.seg_out, 64'h0);
        chk64("reset_seg_sel", 64'(bus.seg_sel), 64'h01);
        bus.wr_en = 1'b0;
        rst = 1'b0;

        // Scan rotation after release
        tick();
        chk64("first_edge_zeros", bus.seg_out, 64'h3F3F3F3F3F3F3F3F);
        tick(2);
        chk64("sel_after_3", 64'(bus.seg_sel), 64'h01);
        tick();
        chk64("sel_after_4", 64'(bus.seg_sel), 64'h02);
        tick(24);
        chk64("sel_after_28", 64'(bus.seg_sel), 64'h80);
        tick(4);
        chk64("sel_after_32", 64'(bus.seg_sel), 64'h01);

        // Decode, blanking
        wr(32'h0123_ABCD);
        chk64("decode_0123ABCD", bus.seg_out, 64'h3F065B4F777C395E);
        bus.blank_lz = 1'b1;
        tick();
        chk64("blank_0123ABCD", bus.seg_out, 64'h00065B4F777C395E);
        wr(32'h0);
        chk64("blank_zero", bus.seg_out, 64'h000000000000003F);
        bus.blank_lz = 1'b0;
        wr(32'h0123_ABCD);

        // Phase marker walks digits 0..4 then disappears
        for (int p = 0; p < 6; p++) begin
            bus.phase = 3'(p);
            tick();
            chk64($sformatf("phase_%0d", p), bus.seg_out, ph_exp[p]);
        end
        bus.phase = 3'd7;

        // Back-to-back writes: last one wins
        bus.wr_en = 1'b1;
        bus.wr_data = 32'h1111_1111;
        tick();
        chk64("b2b_first", bus.seg_out, 64'h0606060606060606);
        bus.wr_data = 32'h2222_2222;
        tick();
        bus.wr_en = 1'b0;
        chk64("b2b_second", bus.seg_out, 64'h5B5B5B5B5B5B5B5B);

        // Mixed vectors checked by the model only
        for (int i = 0; i < 24; i++) begin
            bus.wr_en    = 1'($urandom_range(0, 1));
            bus.wr_data  = $urandom >> (4 * $urandom_range(0, 7));
            bus.phase    = 3'($urandom_range(0, 7));
            bus.blank_lz = 1'($urandom_range(0, 1));
            tick();
        end
        bus.wr_en = 1'b0;
        tick(5);

        // Asynchronous reset mid-scan, seen before the next edge
        #2 rst = 1'b1;
        #1;
        chk64("async_rst_seg_out", bus.seg_out, 64'h0);
        chk64("async_rst_seg_sel", 64'(bus.seg_sel), 64'h01);
        tick(2);
        rst = 1'b0;
        tick(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
